// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache fills and D-cache write-back/fill onto one line adapter; adapter request one cycle after grant, ready one cycle after ad_ready.
// Requesters hold req until ready; ties are round-robin, or always D-cache when ARB_FIXED_PRIO_EN is defined.
module cache_mem_arbiter (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_req,
  input  logic [31:0]  i_addr,
  output logic         i_ready,
  output logic [255:0] i_line,
  input  logic         d_req,
  input  logic         d_dirty,
  input  logic [31:0]  d_addr,
  input  logic [31:0]  d_victim_addr,
  input  logic [255:0] d_wline,
  output logic         d_ready,
  output logic [255:0] d_line,
  output logic         ad_re,
  output logic         ad_we,
  output logic [31:0]  ad_addr,
  output logic [255:0] ad_wline,
  input  logic [255:0] ad_rline,
  input  logic         ad_ready
);

  typedef enum logic [2:0] {IDLE, I_FILL, D_WB, D_FILL, RESP} state_t;

  // Line-granular transaction captured when leaving IDLE.
  typedef struct packed {
    logic [26:0]  line_idx;
    logic [26:0]  victim_idx;
    logic [255:0] wline;
    logic         is_d;
  } txn_t;

  state_t       state, state_nxt;
  txn_t         txn_q;
  logic [255:0] line_q;
  logic         grant_any;
  logic         grant_d;

`ifdef ARB_FIXED_PRIO_EN
  assign grant_d = d_req;
`else
  logic last_d_q;
  assign grant_d = d_req & (~i_req | ~last_d_q);
`endif

  assign grant_any = i_req | d_req;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_any) begin
          if (grant_d) state_nxt = d_dirty ? D_WB : D_FILL;
          else         state_nxt = I_FILL;
        end
      end
      I_FILL:  if (ad_ready) state_nxt = RESP;
      D_WB:    if (ad_ready) state_nxt = D_FILL;
      D_FILL:  if (ad_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      txn_q  <= '0;
      line_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_any) begin
        txn_q.line_idx   <= grant_d ? d_addr[31:5] : i_addr[31:5];
        txn_q.victim_idx <= d_victim_addr[31:5];
        txn_q.wline      <= d_wline;
        txn_q.is_d       <= grant_d;
      end
      if ((state == I_FILL || state == D_FILL) && ad_ready) begin
        line_q <= ad_rline;
`ifndef ARB_FIXED_PRIO_EN
        last_d_q <= txn_q.is_d;
`endif
      end
    end
  end

  always_comb begin
    ad_re    = 1'b0;
    ad_we    = 1'b0;
    ad_addr  = '0;
    ad_wline = '0;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    i_line   = '0;
    d_line   = '0;
    case (state)
      I_FILL, D_FILL: begin
        ad_re   = 1'b1;
        ad_addr = {txn_q.line_idx, 5'b0};
      end
      D_WB: begin
        ad_we    = 1'b1;
        ad_addr  = {txn_q.victim_idx, 5'b0};
        ad_wline = txn_q.wline;
      end
      RESP: begin
        ad_addr = {txn_q.line_idx, 5'b0};
        if (txn_q.is_d) begin
          d_ready = 1'b1;
          d_line  = line_q;
        end else begin
          i_ready = 1'b1;
          i_line  = line_q;
        end
      end
      default: ;
    endcase
  end

endmodule
